// File: rtl/psa_16bit.sv
// 16-bit adder/subtractor: full-width two's-complement or 4x4-bit saturating packed lanes,
// plus a sticky overflow flag. Define PSA_16BIT_SAT_EN to make the 16-bit mode saturate too.

module psa_16bit_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       ovfl,
  output logic       gg,
  output logic       gp
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovfl = c[3] ^ c[4];
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp   = &p;
endmodule

module psa_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Sub,
  input  logic        pad,
  input  logic        clr,
  output logic [15:0] Sum,
  output logic        Ovfl,
  output logic        Ovfl_sticky
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 4;

  logic [NUM_LANES-1:0][LANE_W-1:0] a_l, b_l, raw_l, sat_l;
  logic [NUM_LANES-1:0]             cin_l, gg_l, gp_l, ovf_l;
  logic [15:0]                      raw, wide_sum;
  logic                             wide_ovfl;

  assign a_l = A;
  assign b_l = Sub ? ~B : B;

  // Inter-lane carries come from lane group generate/propagate, so no lane waits on another.
  always_comb begin : lane_carry
    logic c;
    c     = Sub;
    cin_l = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cin_l[i] = pad ? Sub : c;
      c        = gg_l[i] | (gp_l[i] & c);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    psa_16bit_cla4 u_lane (
      .a    (a_l[i]),
      .b    (b_l[i]),
      .cin  (cin_l[i]),
      .sum  (raw_l[i]),
      .ovfl (ovf_l[i]),
      .gg   (gg_l[i]),
      .gp   (gp_l[i])
    );
    // An overflowed result has the wrong sign: negative-looking means positive overflow.
    assign sat_l[i] = ovf_l[i] ? (raw_l[i][LANE_W-1] ? 4'h7 : 4'h8) : raw_l[i];
  end

  assign raw       = raw_l;
  assign wide_ovfl = ovf_l[NUM_LANES-1];

`ifdef PSA_16BIT_SAT_EN
  assign wide_sum = wide_ovfl ? (raw[15] ? 16'h7FFF : 16'h8000) : raw;
`else
  assign wide_sum = raw;
`endif

  assign Sum  = pad ? sat_l : wide_sum;
  assign Ovfl = pad ? |ovf_l : wide_ovfl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      Ovfl_sticky <= 1'b0;
    else if (clr) Ovfl_sticky <= 1'b0;
    else          Ovfl_sticky <= Ovfl_sticky | Ovfl;
  end
endmodule

// File: tb/tb_psa_16bit.sv
// Directed + random bench for psa_16bit: scoreboard of expected Sum/Ovfl, sticky flag sequence.

module tb_psa_16bit;
  typedef struct packed {
    logic [15:0] sum;
    logic        ovfl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, Sub, pad, clr;
  logic [15:0] A, B, Sum;
  logic        Ovfl, Ovfl_sticky;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  psa_16bit dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .Sub         (Sub),
    .pad         (pad),
    .clr         (clr),
    .Sum         (Sum),
    .Ovfl        (Ovfl),
    .Ovfl_sticky (Ovfl_sticky)
  );

  always #5 clk = ~clk;

  // Independent integer model of both modes.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic p);
    exp_t r;
    int   x, y, s;
    r.ovfl = 1'b0;
    r.sum  = '0;
    if (!p) begin
      x = $signed(a);
      y = $signed(b);
      s = sub ? x - y : x + y;
      r.ovfl = (s > 32767) || (s < -32768);
      r.sum  = s[15:0];
`ifdef PSA_16BIT_SAT_EN
      if (s > 32767)  r.sum = 16'h7FFF;
      if (s < -32768) r.sum = 16'h8000;
`endif
    end else begin
      for (int i = 0; i < 4; i++) begin
        x = $signed(a[4*i +: 4]);
        y = $signed(b[4*i +: 4]);
        s = sub ? x - y : x + y;
        if (s > 7) begin
          r.sum[4*i +: 4] = 4'h7;
          r.ovfl = 1'b1;
        end else if (s < -8) begin
          r.sum[4*i +: 4] = 4'h8;
          r.ovfl = 1'b1;
        end else begin
          r.sum[4*i +: 4] = s[3:0];
        end
      end
    end
    return r;
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic p, input exp_t e);
    A = a; B = b; Sub = sub; pad = p;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    #1;
    e = sb.pop_front();
    checks++;
    assert (Sum === e.sum) else begin
      errors++;
      $error("FAIL %s Sum got %h want %h", tag, Sum, e.sum);
    end
    checks++;
    assert (Ovfl === e.ovfl) else begin
      errors++;
      $error("FAIL %s Ovfl got %b want %b", tag, Ovfl, e.ovfl);
    end
  endtask

  task automatic check_sticky(input string tag, input logic want);
    checks++;
    assert (Ovfl_sticky === want) else begin
      errors++;
      $error("FAIL %s Ovfl_sticky got %b want %b", tag, Ovfl_sticky, want);
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rs, rp;
    rst = 1'b1; clr = 1'b1; A = '0; B = '0; Sub = 1'b0; pad = 1'b0;
    #2;
    check_sticky("reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, expectations written out by hand.
    drive(16'h0000, 16'h0002, 1'b0, 1'b0, '{16'h0002, 1'b0}); check_out("pc_plus2");
`ifdef PSA_16BIT_SAT_EN
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h7FFF, 1'b1}); check_out("add_posovf");
`else
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b1}); check_out("add_posovf");
`endif
    drive(16'h0005, 16'h0007, 1'b1, 1'b0, '{16'hFFFE, 1'b0}); check_out("sub_neg");
`ifdef PSA_16BIT_SAT_EN
    drive(16'h8000, 16'h0001, 1'b1, 1'b0, '{16'h8000, 1'b1}); check_out("sub_negovf");
`else
    drive(16'h8000, 16'h0001, 1'b1, 1'b0, '{16'h7FFF, 1'b1}); check_out("sub_negovf");
`endif
    drive(16'h7181, 16'h1188, 1'b0, 1'b1, '{16'h7289, 1'b1}); check_out("pad_add");
    drive(16'h8000, 16'h1000, 1'b1, 1'b1, '{16'h8000, 1'b1}); check_out("pad_sub");
    drive(16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0}); check_out("carry_chain");
    drive(16'h00FF, 16'h0001, 1'b0, 1'b1, '{16'h00F0, 1'b0}); check_out("pad_cut_carry");
    drive(16'h1234, 16'h1234, 1'b1, 1'b1, '{16'h0000, 1'b0}); check_out("pad_self_sub");
    drive(16'h0000, 16'h8888, 1'b1, 1'b1, '{16'h7777, 1'b1}); check_out("pad_sub_min");

    // Random vectors against the model.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom_range(1)); rp = 1'($urandom_range(1));
      drive(ra, rb, rs, rp, model(ra, rb, rs, rp));
      check_out("random");
    end

    // Sticky sequence: set, hold, clr beats Ovfl, set again, async reset mid-cycle.
    @(negedge clk);
    clr = 1'b0;
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, model(16'h7FFF, 16'h0001, 1'b0, 1'b0));
    check_out("stk_set_vec");
    check_sticky("stk_before_edge", 1'b0);
    @(posedge clk); #1;
    check_sticky("stk_set", 1'b1);
    @(negedge clk);
    drive(16'h0001, 16'h0001, 1'b0, 1'b0, '{16'h0002, 1'b0}); check_out("stk_quiet_vec");
    @(posedge clk); #1;
    check_sticky("stk_hold", 1'b1);
    @(negedge clk);
    clr = 1'b1;
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, model(16'h7FFF, 16'h0001, 1'b0, 1'b0));
    check_out("stk_clr_vec");
    @(posedge clk); #1;
    check_sticky("stk_clr_wins", 1'b0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;
    check_sticky("stk_reset_again", 1'b1);
    @(negedge clk);
    A = 16'h0001; B = 16'h0001;
    #1 rst = 1'b1;
    #1 check_sticky("stk_async_rst", 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_sticky("stk_after_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
